// File: rtl/rc4_stream_xor.sv
`default_nettype none
// ============================================================================
// Module   : rc4_stream_xor
// Purpose  : XORs a byte stream with RC4 keystream buffered in a small FIFO,
//            counts message length and flags the last byte.
// Options  : RC4_DROP_EN adds the RC4-drop[DROP_N] discard phase after rekey.
// Revision : 1.0
// ============================================================================
module rc4_stream_xor #(
  parameter int KS_DEPTH = 4,
  parameter int LEN_W    = 16,
  parameter int DROP_N   = 768
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             new_key,
  input  logic [LEN_W-1:0] msg_len,
  output logic             busy,
  output logic             done,
  input  logic             ks_valid,
  input  logic [7:0]       ks_data,
  output logic             ks_ready,
  input  logic             din_valid,
  input  logic [7:0]       din_data,
  output logic             din_ready,
  output logic             dout_valid,
  output logic [7:0]       dout_data,
  output logic             dout_last,
  input  logic             dout_ready
);

  localparam int PTR_W = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
`ifdef RC4_DROP_EN
    S_DROP = 2'd3,
`endif
    S_DONE = 2'd2
  } state_t;

  if (KS_DEPTH < 2 || (KS_DEPTH & (KS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("KS_DEPTH must be a power of 2 and >= 2");
  end
  if (DROP_N < 1) begin : g_bad_drop
    $error("DROP_N must be >= 1");
  end

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_fifo [KS_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [LEN_W-1:0] r_remaining;
  logic             w_start_ok, w_flush, w_push, w_pop, w_out_free;

  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_flush    = w_start_ok && new_key;
  assign w_out_free = !dout_valid || dout_ready;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

  always_comb begin
    ks_ready  = (r_state == S_RUN) && (r_count < CNT_W'(KS_DEPTH));
`ifdef RC4_DROP_EN
    if (r_state == S_DROP) ks_ready = 1'b1;
`endif
    din_ready = (r_state == S_RUN) && (r_count != '0) &&
                (r_remaining != '0) && w_out_free;
  end

  assign w_push = ks_valid && ks_ready && (r_state == S_RUN);
  assign w_pop  = din_valid && din_ready;

`ifdef RC4_DROP_EN
  localparam int DROP_W = $clog2(DROP_N + 1);
  logic [DROP_W-1:0] r_drop_cnt;
  logic              w_drop_last;

  assign w_drop_last = (r_drop_cnt == DROP_W'(DROP_N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || w_start_ok) r_drop_cnt <= '0;
    else if (r_state == S_DROP && ks_valid) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef RC4_DROP_EN
          w_state_nxt = new_key ? S_DROP : S_RUN;
`else
          w_state_nxt = S_RUN;
`endif
        end
      end
`ifdef RC4_DROP_EN
      S_DROP: if (ks_valid && w_drop_last) w_state_nxt = S_RUN;
`endif
      // The final byte may still be waiting downstream; leave only once it drains.
      S_RUN:  if (r_remaining == '0 && w_out_free) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= ks_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      dout_valid  <= 1'b0;
      dout_data   <= 8'h00;
      dout_last   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_start_ok)  r_remaining <= msg_len;
      else if (w_pop)  r_remaining <= r_remaining - LEN_W'(1);

      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
        else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      end

      if (w_pop) begin
        dout_valid <= 1'b1;
        dout_data  <= din_data ^ r_fifo[r_rd_ptr];
        dout_last  <= (r_remaining == LEN_W'(1));
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rc4_stream_xor.sv
`default_nettype none
// Bench for rc4_stream_xor: directed RC4 "Key" vectors fed through keystream,
// input and output agents with hand-computed expected bytes.
module tb_rc4_stream_xor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        new_key = 1'b0;
  logic [15:0] msg_len = 16'd0;
  logic        busy, done;
  logic        ks_valid = 1'b0;
  logic [7:0]  ks_data = 8'h00;
  logic        ks_ready;
  logic        din_valid = 1'b0;
  logic [7:0]  din_data = 8'h00;
  logic        din_ready;
  logic        dout_valid;
  logic [7:0]  dout_data;
  logic        dout_last;
  logic        dout_ready = 1'b1;

  rc4_stream_xor #(.KS_DEPTH(4), .LEN_W(16), .DROP_N(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .new_key(new_key), .msg_len(msg_len),
    .busy(busy), .done(done), .ks_valid(ks_valid), .ks_data(ks_data), .ks_ready(ks_ready),
    .din_valid(din_valid), .din_data(din_data), .din_ready(din_ready),
    .dout_valid(dout_valid), .dout_data(dout_data), .dout_last(dout_last),
    .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] ks_tab [16];
  logic [7:0] pt [9];
  logic [7:0] ct [9];
  logic [7:0] din_q [16];
  logic [7:0] exp_q [16];
  int  ks_idx = 0, din_idx = 0, din_n = 0, rx_idx = 0, last_hs_cyc = 0;
  bit  ks_gap = 0, rdy_rand = 0, ks_hs = 0, din_hs = 0, stalled = 0;
  logic [7:0] held = 8'h00;

  // Agents: drive at +1 after the edge, sample handshakes at +8.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (ks_hs)  ks_idx++;
      if (din_hs) din_idx++;
      ks_valid   = !ks_gap || ($urandom_range(0, 2) != 0);
      ks_data    = (ks_idx < 16) ? ks_tab[ks_idx] : 8'h00;
      din_valid  = (din_idx < din_n);
      din_data   = (din_idx < 16) ? din_q[din_idx] : 8'h00;
      dout_ready = !rdy_rand || ($urandom_range(0, 1) == 1);
      #7;
      if (stalled) check_val("stall_hold", {dout_valid, dout_data}, {1'b1, held});
      ks_hs  = ks_valid && ks_ready;
      din_hs = din_valid && din_ready;
      if (dout_valid && dout_ready) begin
        if (rx_idx < din_n && rx_idx < 16) begin
          check_val($sformatf("dout[%0d]", rx_idx), dout_data, exp_q[rx_idx]);
          check_val($sformatf("last[%0d]", rx_idx), dout_last, (rx_idx == din_n - 1));
        end else begin
          check_val("extra_dout", rx_idx, din_n - 1);
        end
        rx_idx++;
        last_hs_cyc = cyc;
      end
      stalled = dout_valid && !dout_ready;
      held    = dout_data;
    end
  end

  task automatic load(input bit decrypt, input int off, input int len);
    for (int i = 0; i < len; i++) begin
      din_q[i] = decrypt ? ct[off + i] : pt[off + i];
      exp_q[i] = decrypt ? pt[off + i] : ct[off + i];
    end
  endtask

  task automatic run_msg(input string tag, input bit nk, input int len, input bit gap, input bit rr);
    int n;
    @(posedge clk); #3;
    if (nk) ks_idx = 0;
    din_idx = 0; rx_idx = 0; din_n = len; ks_gap = gap; rdy_rand = rr; stalled = 0;
    start = 1'b1; new_key = nk; msg_len = 16'(len);
    @(posedge clk); #3;
    start = 1'b0; new_key = 1'b0;
    check_val({tag, "_busy"}, busy, 1);
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk); #5;
      n++;
    end
    check_val({tag, "_done_seen"}, done, 1);
    check_val({tag, "_count"}, rx_idx, len);
    if (len > 0) check_val({tag, "_done_lat"}, cyc, last_hs_cyc + 1);
    @(posedge clk); #5;
    check_val({tag, "_done_pulse"}, {done, busy}, 0);
    ks_gap = 0; rdy_rand = 0;
  endtask

  task automatic reset_mid_msg();
    load(0, 0, 9);
    run_start_only();
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("rst_ctl", {busy, done, ks_ready, din_ready, dout_valid, dout_last}, 0);
    check_val("rst_data", dout_data, 0);
    check_val("rst_count", dut.r_count, 0);
    #2 rst_n = 1'b1;
  endtask

  task automatic run_start_only();
    @(posedge clk); #3;
    ks_idx = 0; din_idx = 0; rx_idx = 0; din_n = 9; rdy_rand = 0; ks_gap = 0;
    start = 1'b1; new_key = 1'b1; msg_len = 16'd9;
    @(posedge clk); #3;
    start = 1'b0; new_key = 1'b0;
  endtask

  initial begin
    int nb, nd, ndr;
    ks_tab = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72,
               8'hA7, 8'h19, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    pt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int i = 0; i < 16; i++) begin
      din_q[i] = 8'h00;
      exp_q[i] = 8'h00;
    end

    repeat (2) @(posedge clk);
    #5;
    check_val("reset_ctl", {busy, done, ks_ready, din_ready, dout_valid, dout_last}, 0);
    check_val("reset_data", dout_data, 0);
    @(posedge clk); #3 rst_n = 1'b1;

`ifdef RC4_DROP_EN
    // Four dropped bytes, so the first output uses keystream byte 5 (B7).
    load(0, 0, 5);
    exp_q[0] = 8'hE7; exp_q[1] = 8'h58; exp_q[2] = 8'hAB; exp_q[3] = 8'h1B; exp_q[4] = 8'hC9;
    run_msg("drop", 1, 5, 0, 0);
    reset_mid_msg();
`else
    load(0, 0, 9);
    run_msg("enc", 1, 9, 0, 0);
    load(1, 0, 9);
    run_msg("dec", 1, 9, 0, 0);
    load(0, 0, 9);
    run_msg("stall", 1, 9, 1, 1);
    load(0, 0, 5);
    run_msg("cont_a", 1, 5, 0, 0);
    load(0, 5, 4);
    run_msg("cont_b", 0, 4, 0, 0);

    @(posedge clk); #3;
    din_n = 0; din_idx = 0; rx_idx = 0;
    start = 1'b1; new_key = 1'b0; msg_len = 16'd0;
    @(posedge clk); #3;
    start = 1'b0;
    nb = 0; nd = 0; ndr = 0;
    repeat (5) begin
      #2;
      nb += busy; nd += done; ndr += din_ready;
      @(posedge clk); #3;
    end
    check_val("zero_busy_cycles", nb, 2);
    check_val("zero_done_cycles", nd, 1);
    check_val("zero_din_ready", ndr, 0);

    reset_mid_msg();
    load(0, 0, 9);
    run_msg("after_rst", 1, 9, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
